// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//
// Serial pattern transmitter. Sends a latched PAT_W-bit pattern MSB-first on a
// single-bit line, repeated rep_cnt times, with GAP idle bit-times between
// repetitions. Every output is registered from the current state, so outputs
// trail the state register by one cycle. A start sampled at edge k therefore
// shows its first bit after edge k+1.
//
// Parameters:
//   PAT_W  pattern width in bits (>= 2)
//   CNT_W  repetition counter width
//   GAP    idle bit-times between repetitions (0 = back-to-back)
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active-low
//   start     transfer request, honoured only in IDLE
//   pat_in    pattern to send, latched on an accepted start
//   rep_cnt   repetition count, latched on an accepted start (0 = done only)
//   abort     cancels an active transfer (SHIFT/GAP), no done pulse
//   ready     1 while IDLE
//   busy      1 while SHIFT or GAP
//   dout      serial data bit (0 whenever dout_vld = 0)
//   dout_vld  1 when dout carries a pattern bit
//   done      one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             dout,
  output logic             dout_vld,
  output logic             done
);

  localparam int IW = $clog2(PAT_W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(PAT_W - 1);
  // With GAP = 0 the gap counter is never loaded; this value is only a filler.
  localparam logic [GW-1:0] GAP_TOP = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [CNT_W-1:0] rep_q,   rep_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [GW-1:0]    gap_q,   gap_d;

  logic ready_q, busy_q, dout_q, dout_vld_q, done_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    gap_d   = gap_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort is ignored here, so a coincident start always wins.
        if (start) begin
          if (rep_cnt != '0) begin
            state_d = ST_SHIFT;
            pat_d   = pat_in;
            rep_d   = rep_cnt;
            idx_d   = IDX_TOP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == '0) begin
          // Last bit of this repetition. Testing the pre-decrement count
          // against 1 lets rep_cnt = 2^CNT_W-1 run to completion without wrap.
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_TOP;
          end else begin
            idx_d = IDX_TOP;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_SHIFT;
          idx_d   = IDX_TOP;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered Moore outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!rst) begin
      // NOTE: the pattern and counters are cleared too, not just the state,
      // so nothing from an interrupted transfer survives a reset.
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      rep_q      <= rep_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      // Outputs are decoded from the current state only, which gives the
      // one-cycle lag between the state register and the pins.
      ready_q    <= (state_q == ST_IDLE);
      busy_q     <= (state_q == ST_SHIFT) || (state_q == ST_GAP);
      dout_vld_q <= (state_q == ST_SHIFT);
      dout_q     <= (state_q == ST_SHIFT) && pat_q[idx_q];
      done_q     <= (state_q == ST_DONE);
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//
// Scoreboard bench for seq_pattern_tx. Two instances share the data inputs:
// dut0 has GAP = 0 and dut2 has GAP = 2. Each one has its own start. Issuing a
// transfer pushes the expected (cycle, bit) and done events into that
// instance's queue. A monitor per instance pops one entry each time the
// instance presents a valid bit or a done pulse, and compares it.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start2;
  logic [3:0] pat_in;
  logic [7:0] rep_cnt;
  logic       abort;

  logic rdy0, bsy0, dat0, vld0, dn0;
  logic rdy2, bsy2, dat2, vld2, dn2;

  int cyc     = 0;
  int n_check = 0;
  int n_err   = 0;

  typedef struct {
    int stamp;
    bit is_done;
    bit val;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pat_in(pat_in), .rep_cnt(rep_cnt),
    .abort(abort), .ready(rdy0), .busy(bsy0), .dout(dat0), .dout_vld(vld0),
    .done(dn0)
  );

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pat_in(pat_in), .rep_cnt(rep_cnt),
    .abort(abort), .ready(rdy2), .busy(bsy2), .dout(dat2), .dout_vld(vld2),
    .done(dn2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_check++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  function automatic int xfer_len(input int r, input int g);
    return (r == 0) ? 0 : r * 4 + (r - 1) * g;
  endfunction

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    exp_t e;
    if (vld0 || dn0) begin
      n_check++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL d0_unexpected @cyc %0d: got vld=%0b done=%0b, required none",
                 cyc, vld0, dn0);
      end else begin
        n_check--;
        e = q0.pop_front();
        check("d0_kind", dn0, e.is_done);
        check("d0_stamp", cyc, e.stamp);
        if (!e.is_done) check("d0_bit", dat0, e.val);
      end
    end
    if (vld0 === 1'b0) check("d0_dout_idle_zero", dat0, 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (vld2 || dn2) begin
      n_check++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL d2_unexpected @cyc %0d: got vld=%0b done=%0b, required none",
                 cyc, vld2, dn2);
      end else begin
        n_check--;
        e = q2.pop_front();
        check("d2_kind", dn2, e.is_done);
        check("d2_stamp", cyc, e.stamp);
        if (!e.is_done) check("d2_bit", dat2, e.val);
      end
    end
    if (vld2 === 1'b0) check("d2_dout_idle_zero", dat2, 0);
  end

  // --------------------------------------------------------------- stimulus
  task automatic wait_until(input int s);
    while (cyc < s) @(negedge clk);
  endtask

  // Called at a negedge. Start is sampled at edge k = cyc+1. Pattern cycle t
  // is expected at stamp k+1+t. Only cycles t < cut are expected (cut < 0
  // means the whole transfer plus its done pulse).
  task automatic issue(input bit sel, input logic [3:0] pat, input int r,
                       input int cut, input bit with_abort, output int k);
    exp_t e;
    int   g;
    g = sel ? 2 : 0;
    k = cyc + 1;
    for (int j = 0; j < r; j++) begin
      for (int b = 0; b < 4; b++) begin
        int t;
        t = j * (4 + g) + b;
        if (cut < 0 || t < cut) begin
          e.stamp = k + 1 + t; e.is_done = 1'b0; e.val = pat[3 - b];
          if (sel) q2.push_back(e); else q0.push_back(e);
        end
      end
    end
    if (cut < 0) begin
      e.stamp = k + 1 + xfer_len(r, g); e.is_done = 1'b1; e.val = 1'b0;
      if (sel) q2.push_back(e); else q0.push_back(e);
    end
    pat_in  = pat;
    rep_cnt = 8'(r);
    abort   = with_abort;
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    abort  = 1'b0;
  endtask

  // Check the done cycle handshake and the return to IDLE one cycle later.
  task automatic finish_xfer(input bit sel, input int k, input int r);
    int d;
    d = k + 1 + xfer_len(r, sel ? 2 : 0);
    wait_until(d);
    check(sel ? "d2_ready_in_done" : "d0_ready_in_done", sel ? rdy2 : rdy0, 0);
    check(sel ? "d2_busy_in_done"  : "d0_busy_in_done",  sel ? bsy2 : bsy0, 0);
    wait_until(d + 1);
    check(sel ? "d2_ready_after" : "d0_ready_after", sel ? rdy2 : rdy0, 1);
  endtask

  initial begin
    int k;
    rst = 1'b0; start0 = 1'b1; start2 = 1'b1;
    pat_in = 4'b1101; rep_cnt = 8'd1; abort = 1'b0;

    // 1. Reset hold with start asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {rdy0, rdy2}, 2'b11);
      check("rst_busy",  {bsy0, bsy2}, 2'b00);
      check("rst_dout",  {dat0, dat2}, 2'b00);
      check("rst_vld",   {vld0, vld2}, 2'b00);
      check("rst_done",  {dn0, dn2},   2'b00);
    end
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", {rdy0, rdy2}, 2'b11);
    check("idle_busy",  {bsy0, bsy2}, 2'b00);

    // 2. Single pattern, GAP = 0.
    issue(1'b0, 4'b1101, 1, -1, 1'b0, k);
    wait_until(k + 2);
    check("d0_busy_mid", bsy0, 1);
    check("d0_ready_mid", rdy0, 0);
    finish_xfer(1'b0, k, 1);

    // 3. Back-to-back repeats.
    issue(1'b0, 4'b1101, 3, -1, 1'b0, k);
    finish_xfer(1'b0, k, 3);

    // 4. Gap insertion on the GAP = 2 instance.
    issue(1'b1, 4'b1011, 2, -1, 1'b0, k);
    wait_until(k + 6);
    check("d2_busy_in_gap", bsy2, 1);
    check("d2_vld_in_gap", vld2, 0);
    finish_xfer(1'b1, k, 2);

    // 5a. Zero repetitions: done only.
    issue(1'b0, 4'b1111, 0, -1, 1'b0, k);
    finish_xfer(1'b0, k, 0);

    // 5b. start while busy with a different pattern is ignored.
    issue(1'b0, 4'b1101, 2, -1, 1'b0, k);
    wait_until(k + 3);
    pat_in = 4'b0110; rep_cnt = 8'd7; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    finish_xfer(1'b0, k, 2);

    // 5c. abort coinciding with start in IDLE: start wins.
    issue(1'b0, 4'b1001, 1, -1, 1'b1, k);
    finish_xfer(1'b0, k, 1);

    // 6a. abort during the second bit of the first repetition.
    issue(1'b0, 4'b1101, 5, 3, 1'b0, k);
    wait_until(k + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(k + 5);
    check("abort_ready", rdy0, 1);
    check("abort_busy", bsy0, 0);
    check("abort_vld", vld0, 0);
    repeat (20) @(negedge clk);

    // 6b. Reset while the GAP = 2 instance is in its gap.
    issue(1'b1, 4'b1011, 5, 4, 1'b0, k);
    wait_until(k + 4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_ready", rdy2, 1);
    check("midrst_busy", bsy2, 0);
    check("midrst_vld", vld2, 0);
    check("midrst_done", dn2, 0);
    repeat (20) @(negedge clk);
    issue(1'b1, 4'b1101, 1, -1, 1'b0, k);
    finish_xfer(1'b1, k, 1);

    // Maximum repetition count completes exactly 255 times.
    issue(1'b0, 4'b1110, 255, -1, 1'b0, k);
    finish_xfer(1'b0, k, 255);

    // Drain the scoreboards, bounded.
    for (int i = 0; i < 100 && (q0.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    check("d0_queue_empty", q0.size(), 0);
    check("d2_queue_empty", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule
